// File: rtl/wb_stage_reg.sv
// wb_stage_reg: write-back pipeline register with decode forwarding and retired-write counter.
// Optional feature: define WB_FORWARD_EN to forward write data to decode; otherwise decode stalls on every dependence.
module wb_stage_reg #(
  parameter int DW = 8,
  parameter int SEL_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             cnt_clr,
  input  logic             ex_valid,
  input  logic [DW-1:0]    ex_alu,
  input  logic [DW-1:0]    ex_or2,
  input  logic [DW-1:0]    ex_dm,
  input  logic [DW-1:0]    ex_sp,
  input  logic [SEL_W-1:0] ex_rn_sel,
  input  logic [1:0]       ex_ctrl,
  input  logic [SEL_W-1:0] ex_s8,
  output logic [DW-1:0]    wb_alu,
  output logic [DW-1:0]    wb_or2,
  output logic [DW-1:0]    wb_dm,
  output logic [DW-1:0]    wb_sp,
  output logic [SEL_W-1:0] wb_rn_sel,
  output logic [1:0]       wb_ctrl,
  output logic [SEL_W-1:0] wb_s8,
  output logic             wb_valid,
  input  logic [SEL_W-1:0] id_rn_sel,
  output logic             fwd_r0_hit,
  output logic             fwd_rn_hit,
  output logic [DW-1:0]    fwd_data,
  output logic             fwd_hazard,
  output logic [CNT_W-1:0] wb_count
);
  logic r0;
  logic rn;
  logic retire;
  assign r0 = wb_valid & wb_ctrl[0];
  assign rn = wb_valid & ((wb_ctrl == 2'b11) |
                          ((wb_ctrl == 2'b10) & (wb_rn_sel == id_rn_sel)) |
                          ((wb_ctrl == 2'b01) & (id_rn_sel == '0)));
  assign retire = wb_valid & (|wb_ctrl) & ~stall & ~flush;
  // stage capture: flush kills valid/ctrl, stall holds everything, otherwise load from execute
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid  <= 1'b0;
      wb_ctrl   <= 2'b00;
      wb_alu    <= '0;
      wb_or2    <= '0;
      wb_dm     <= '0;
      wb_sp     <= '0;
      wb_rn_sel <= '0;
      wb_s8     <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      wb_ctrl  <= 2'b00;
    end else if (!stall) begin
      wb_valid  <= ex_valid;
      wb_ctrl   <= ex_valid ? ex_ctrl : 2'b00;
      wb_alu    <= ex_alu;
      wb_or2    <= ex_or2;
      wb_dm     <= ex_dm;
      wb_sp     <= ex_sp;
      wb_rn_sel <= ex_rn_sel;
      wb_s8     <= ex_s8;
    end
  end
  // retired-write counter: clear wins, increment saturates at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wb_count <= '0;
    else if (cnt_clr) wb_count <= '0;
    else if (retire && !(&wb_count)) wb_count <= wb_count + 1'b1;
  end
`ifdef WB_FORWARD_EN
  logic copy;
  assign copy = (wb_s8 == SEL_W'(5)) | (wb_s8 == SEL_W'(6));
  // copy sources have no value yet, so their dependences become hazards instead of hits
  always_comb begin
    fwd_data   = (wb_s8 == SEL_W'(1)) ? wb_alu :
                 (wb_s8 == SEL_W'(2)) ? wb_or2 :
                 (wb_s8 == SEL_W'(3)) ? wb_sp  :
                 (wb_s8 == SEL_W'(4)) ? wb_dm  : '0;
    fwd_r0_hit = ~copy & r0;
    fwd_rn_hit = ~copy & rn;
    fwd_hazard = copy & (r0 | rn);
  end
`else
  // no forwarding path: every dependence stalls decode
  always_comb begin
    fwd_data   = '0;
    fwd_r0_hit = 1'b0;
    fwd_rn_hit = 1'b0;
    fwd_hazard = r0 | rn;
  end
`endif
endmodule

// File: tb/tb_wb_stage_reg.sv
// tb_wb_stage_reg: randomized and directed checks of wb_stage_reg against a behavioural model.
module tb_wb_stage_reg;
  logic       clk = 1'b0;
  logic       rst_n, stall, flush, cnt_clr, ex_valid;
  logic [7:0] ex_alu, ex_or2, ex_dm, ex_sp;
  logic [2:0] ex_rn_sel, ex_s8, id_rn_sel;
  logic [1:0] ex_ctrl;
  logic [7:0] wb_alu, wb_or2, wb_dm, wb_sp, fwd_data;
  logic [2:0] wb_rn_sel, wb_s8;
  logic [1:0] wb_ctrl;
  logic       wb_valid, fwd_r0_hit, fwd_rn_hit, fwd_hazard;
  logic [15:0] wb_count;
  int checks = 0;
  int errors = 0;
  // behavioural model of the stage contents and the counter
  bit       m_valid;
  bit [1:0] m_ctrl;
  bit [7:0] m_alu, m_or2, m_dm, m_sp;
  bit [2:0] m_sel, m_s8;
  int       m_cnt;

  wb_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .ex_valid(ex_valid), .ex_alu(ex_alu), .ex_or2(ex_or2), .ex_dm(ex_dm), .ex_sp(ex_sp),
    .ex_rn_sel(ex_rn_sel), .ex_ctrl(ex_ctrl), .ex_s8(ex_s8),
    .wb_alu(wb_alu), .wb_or2(wb_or2), .wb_dm(wb_dm), .wb_sp(wb_sp),
    .wb_rn_sel(wb_rn_sel), .wb_ctrl(wb_ctrl), .wb_s8(wb_s8), .wb_valid(wb_valid),
    .id_rn_sel(id_rn_sel), .fwd_r0_hit(fwd_r0_hit), .fwd_rn_hit(fwd_rn_hit),
    .fwd_data(fwd_data), .fwd_hazard(fwd_hazard), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_ctrl = 0; m_alu = 0; m_or2 = 0; m_dm = 0; m_sp = 0;
    m_sel = 0; m_s8 = 0; m_cnt = 0;
  endtask

  // one clock edge; model follows the written rules using the inputs seen at the edge
  task automatic step();
    bit ret;
    ret = m_valid && m_ctrl != 0 && !stall && !flush;
    @(posedge clk);
    if (cnt_clr) m_cnt = 0;
    else if (ret && m_cnt < 65535) m_cnt++;
    if (flush) begin
      m_valid = 0; m_ctrl = 0;
    end else if (!stall) begin
      m_valid = ex_valid; m_ctrl = ex_valid ? ex_ctrl : 2'b00;
      m_alu = ex_alu; m_or2 = ex_or2; m_dm = ex_dm; m_sp = ex_sp;
      m_sel = ex_rn_sel; m_s8 = ex_s8;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    bit r0, rn, copy, e_r0, e_rn, e_hz;
    bit [7:0] e_d;
    r0 = m_valid && m_ctrl[0];
    rn = m_valid && (m_ctrl == 3 || (m_ctrl == 2 && m_sel == id_rn_sel) || (m_ctrl == 1 && id_rn_sel == 0));
    copy = (m_s8 == 5) || (m_s8 == 6);
    case (m_s8)
      3'd1: e_d = m_alu;
      3'd2: e_d = m_or2;
      3'd3: e_d = m_sp;
      3'd4: e_d = m_dm;
      default: e_d = 8'h00;
    endcase
`ifdef WB_FORWARD_EN
    e_r0 = copy ? 1'b0 : r0;
    e_rn = copy ? 1'b0 : rn;
    e_hz = copy && (r0 || rn);
`else
    e_r0 = 0; e_rn = 0; e_hz = r0 || rn;
    copy = 0; e_d = 8'h00;
`endif
    chk({tag, ".valid"}, wb_valid, m_valid);
    chk({tag, ".ctrl"}, wb_ctrl, m_ctrl);
    chk({tag, ".alu"}, wb_alu, m_alu);
    chk({tag, ".or2"}, wb_or2, m_or2);
    chk({tag, ".dm"}, wb_dm, m_dm);
    chk({tag, ".sp"}, wb_sp, m_sp);
    chk({tag, ".sel"}, wb_rn_sel, m_sel);
    chk({tag, ".s8"}, wb_s8, m_s8);
    chk({tag, ".cnt"}, wb_count, m_cnt);
    chk({tag, ".r0hit"}, fwd_r0_hit, e_r0);
    chk({tag, ".rnhit"}, fwd_rn_hit, e_rn);
    chk({tag, ".hazard"}, fwd_hazard, e_hz);
    if (!copy) chk({tag, ".fdata"}, fwd_data, e_d);
  endtask

  task automatic load(input bit v, input bit [1:0] c, input bit [2:0] sel, input bit [2:0] s8);
    ex_valid = v; ex_ctrl = c; ex_rn_sel = sel; ex_s8 = s8;
  endtask

  initial begin
    rst_n = 0; stall = 0; flush = 0; cnt_clr = 0; id_rn_sel = 0;
    ex_alu = 0; ex_or2 = 0; ex_dm = 0; ex_sp = 0;
    load(0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1;
    // a few loaded writes, then reset mid-cycle while stall and flush are active
    for (int i = 0; i < 4; i++) begin
      ex_alu = 8'($urandom); ex_dm = 8'($urandom);
      load(1, 2'($urandom_range(1, 3)), 3'($urandom), 3'($urandom_range(1, 4)));
      step();
    end
    stall = 1; flush = 1;
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all("t1.async_rst");
    @(negedge clk);
    rst_n = 1; stall = 0; flush = 0;
    ex_alu = 8'h5A;
    load(1, 2'b10, 3'd3, 3'b001);
    step();
    check_all("t1.load");
    chk("t1.alu_5a", wb_alu, 8'h5A);
    chk("t1.ctrl_10", wb_ctrl, 2'b10);
    chk("t1.valid", wb_valid, 1'b1);
    // flush together with stall kills the held write and does not count it
    stall = 1; flush = 1;
    step();
    check_all("t2.flush_stall");
    chk("t2.valid0", wb_valid, 1'b0);
    chk("t2.cnt", wb_count, 16'd0);
    stall = 0; flush = 0;
    // DM source forwarded to a matching RN read
    ex_dm = 8'h3C;
    load(1, 2'b10, 3'd5, 3'b100);
    step();
    id_rn_sel = 3'd5; #1;
    check_all("t3.match");
`ifdef WB_FORWARD_EN
    chk("t3.rnhit", fwd_rn_hit, 1'b1);
    chk("t3.data", fwd_data, 8'h3C);
`else
    chk("t3.hazard", fwd_hazard, 1'b1);
`endif
    id_rn_sel = 3'd4; #1;
    check_all("t3.nomatch");
    chk("t3.rnhit0", fwd_rn_hit, 1'b0);
    // broadcast with a copy source
    load(1, 2'b11, 3'd2, 3'b110);
    step();
    check_all("t4.copy");
    chk("t4.hazard", fwd_hazard, 1'b1);
    chk("t4.r0hit0", fwd_r0_hit, 1'b0);
    chk("t4.rnhit0", fwd_rn_hit, 1'b0);
    load(1, 2'b11, 3'd2, 3'b001);
    step();
    check_all("t4.alu_src");
    // invalid instruction must not write, hit or count
    load(0, 2'b11, 3'd1, 3'b001);
    step();
    check_all("t6.invalid");
    chk("t6.ctrl00", wb_ctrl, 2'b00);
    step();
    check_all("t6.no_count");
    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      cnt_clr = ($urandom_range(0, 15) == 0);
      ex_alu = 8'($urandom); ex_or2 = 8'($urandom); ex_dm = 8'($urandom); ex_sp = 8'($urandom);
      load(1'($urandom), 2'($urandom), 3'($urandom), 3'($urandom));
      id_rn_sel = 3'($urandom);
      step();
      check_all("rand");
      id_rn_sel = 3'($urandom); #1;
      check_all("rand.id");
    end
    stall = 0; flush = 0; cnt_clr = 1;
    step();
    check_all("t5.clear");
    cnt_clr = 0;
    // climb the counter to 0xFFFE with back-to-back R0 writes
    load(1, 2'b01, 3'd0, 3'b001);
    for (int i = 0; i < 70000 && m_cnt != 32'hFFFE; i++) step();
    check_all("t5.fffe");
    chk("t5.fffe_const", wb_count, 16'hFFFE);
    repeat (3) step();
    check_all("t5.sat");
    chk("t5.ffff", wb_count, 16'hFFFF);
    cnt_clr = 1;
    step();
    check_all("t5.clr_retire");
    chk("t5.zero", wb_count, 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
